// File: rtl/clk_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_rst_pkg
// Brief    : Shared state encoding, default timing and counter width for the
//            DCM clock/reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package clk_rst_pkg;

    localparam int CNT_W               = 16;
    localparam int RETRY_W             = 4;

    localparam int DEF_DCM_RST_CYCLES  = 4;
    localparam int DEF_LOCK_TIMEOUT    = 65535;
    localparam int DEF_STABLE_CYCLES   = 1024;
    localparam int DEF_CPU_DELAY       = 256;

    typedef enum logic [2:0] {
        ST_DCM_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_VID_UP    = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Brief    : Two-flop synchronizer, asynchronously cleared to 0 on rst.
// Revision : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : clk_rst_seq
// Brief    : Pulses the DCM resets, waits for stable lock, then releases the
//            video and CPU domain resets in order.
// Revision : 1.0 - initial release
// ============================================================================
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int DCM_RST_CYCLES = DEF_DCM_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int CPU_DELAY      = DEF_CPU_DELAY
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               locked_cpu,
    input  logic               locked_video,
    output logic               dcm_rst,
    output logic               vid_rst,
    output logic               cpu_rst,
    output logic               ready,
    output logic [RETRY_W-1:0] retries
);

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0]   c_DCM_LOAD    = CNT_W'(DCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_WAIT_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   c_STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_CPU_LOAD    = CNT_W'(CPU_DELAY - 1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE     = CNT_W'(1);
    localparam logic [RETRY_W-1:0] c_RETRY_ONE   = RETRY_W'(1);

    logic             w_lock_cpu;
    logic             w_lock_vid;
    logic             w_lock_ok;
    logic             w_cnt_zero;
    logic             w_retry_inc;
    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retries;
    logic               r_dcm_rst;
    logic               r_vid_rst;
    logic               r_cpu_rst;
    logic               r_ready;

    sync2 u_sync_cpu (
        .clk (CLK),
        .rst (RST),
        .i_d (locked_cpu),
        .o_q (w_lock_cpu)
    );

    sync2 u_sync_vid (
        .clk (CLK),
        .rst (RST),
        .i_d (locked_video),
        .o_q (w_lock_vid)
    );

    assign w_lock_ok  = w_lock_cpu & w_lock_vid;
    assign w_cnt_zero = (r_cnt == '0);

    // Lock loss takes priority over counter expiry in every lock-watching state.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_retry_inc  = 1'b0;
        case (r_state)
            ST_DCM_RST: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cnt   = c_WAIT_LOAD;
                end else begin
                    w_next_cnt   = r_cnt - c_CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (w_lock_ok) begin
                    w_next_state = ST_STABLE;
                    w_next_cnt   = c_STABLE_LOAD;
                end else if (w_cnt_zero) begin
                    w_next_state = ST_DCM_RST;
                    w_next_cnt   = c_DCM_LOAD;
                    w_retry_inc  = 1'b1;
                end else begin
                    w_next_cnt   = r_cnt - c_CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (!w_lock_ok) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_cnt   = c_WAIT_LOAD;
                end else if (w_cnt_zero) begin
                    w_next_state = ST_VID_UP;
                    w_next_cnt   = c_CPU_LOAD;
                end else begin
                    w_next_cnt   = r_cnt - c_CNT_ONE;
                end
            end
            ST_VID_UP: begin
                if (!w_lock_ok) begin
                    w_next_state = ST_DCM_RST;
                    w_next_cnt   = c_DCM_LOAD;
                    w_retry_inc  = 1'b1;
                end else if (w_cnt_zero) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_cnt   = r_cnt - c_CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!w_lock_ok) begin
                    w_next_state = ST_DCM_RST;
                    w_next_cnt   = c_DCM_LOAD;
                    w_retry_inc  = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_DCM_RST;
                w_next_cnt   = c_DCM_LOAD;
            end
        endcase
    end

    // Outputs decode the next state so they switch on the transition edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_DCM_RST;
            r_cnt     <= c_DCM_LOAD;
            r_retries <= '0;
            r_dcm_rst <= 1'b1;
            r_vid_rst <= 1'b1;
            r_cpu_rst <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            if (w_retry_inc && (r_retries != '1)) begin
                r_retries <= r_retries + c_RETRY_ONE;
            end
            r_dcm_rst <= (w_next_state == ST_DCM_RST);
            r_vid_rst <= (w_next_state == ST_DCM_RST) || (w_next_state == ST_WAIT_LOCK)
                         || (w_next_state == ST_STABLE);
            r_cpu_rst <= (w_next_state != ST_RUN);
            r_ready   <= (w_next_state == ST_RUN);
        end
    end

    assign dcm_rst = r_dcm_rst;
    assign vid_rst = r_vid_rst;
    assign cpu_rst = r_cpu_rst;
    assign ready   = r_ready;
    assign retries = r_retries;

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_rst_seq
// Brief    : Scoreboarded bench for clk_rst_seq; expected per-cycle output
//            vectors {dcm_rst,vid_rst,cpu_rst,ready,retries} are queued up front.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_rst_seq;

    localparam logic [3:0] P_D = 4'b1110;  // DCM_RST
    localparam logic [3:0] P_W = 4'b0110;  // WAIT_LOCK / STABLE
    localparam logic [3:0] P_V = 4'b0010;  // VID_UP
    localparam logic [3:0] P_R = 4'b0001;  // RUN

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       lk_cpu = 1'b0;
    logic       lk_vid = 1'b0;
    logic       dcm_rst;
    logic       vid_rst;
    logic       cpu_rst;
    logic       ready;
    logic [3:0] retries;
    logic [7:0] w_obs;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    clk_rst_seq #(
        .DCM_RST_CYCLES (4),
        .LOCK_TIMEOUT   (32),
        .STABLE_CYCLES  (8),
        .CPU_DELAY      (5)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .locked_cpu   (lk_cpu),
        .locked_video (lk_vid),
        .dcm_rst      (dcm_rst),
        .vid_rst      (vid_rst),
        .cpu_rst      (cpu_rst),
        .ready        (ready),
        .retries      (retries)
    );

    assign w_obs = {dcm_rst, vid_rst, cpu_rst, ready, retries};

    task automatic push(input logic [3:0] ctl, input int r, input int n);
        for (int i = 0; i < n; i++) sb.push_back({ctl, 4'(r)});
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1; lk_cpu = 1'b0; lk_vid = 1'b0;
        sb.delete();
        push(P_D, 0, 3);
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL reset cycle %0d: outputs %b, expected %b", k, w_obs, exp);
            end
        end
    endtask

    // Expects RST high on entry; releases it and raises both locks 10 cycles later.
    task automatic test_bring_up(input string tag);
        logic [7:0] exp;
        lk_cpu = 1'b0; lk_vid = 1'b0;
        sb.delete();
        push(P_D, 0, 3); push(P_W, 0, 17); push(P_V, 0, 5); push(P_R, 0, 3);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs %b, expected %b", tag, k, w_obs, exp);
            end
            if (k == 10) begin lk_cpu = 1'b1; lk_vid = 1'b1; end
        end
    endtask

    task automatic test_chatter();
        logic [7:0] exp;
        rst = 1'b1; lk_cpu = 1'b0; lk_vid = 1'b0;
        @(negedge clk);
        sb.delete();
        push(P_D, 0, 3); push(P_W, 0, 26); push(P_V, 0, 5); push(P_R, 0, 2);
        rst = 1'b0;
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL chatter cycle %0d: outputs %b, expected %b", k, w_obs, exp);
            end
            if (k == 10) begin lk_cpu = 1'b1; lk_vid = 1'b1; end
            if (k == 17) lk_cpu = 1'b0;
            if (k == 19) lk_cpu = 1'b1;
        end
    endtask

    task automatic test_run_loss();
        logic [7:0] exp;
        sb.delete();
        push(P_R, 0, 2); push(P_D, 1, 4); push(P_W, 1, 9); push(P_V, 1, 5); push(P_R, 1, 2);
        lk_vid = 1'b0;
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL run_loss cycle %0d: outputs %b, expected %b", k, w_obs, exp);
            end
            if (k == 3) lk_vid = 1'b1;
        end
    endtask

    task automatic test_vidup_loss();
        logic [7:0] exp;
        sb.delete();
        push(P_R, 1, 2); push(P_D, 2, 4); push(P_W, 2, 9); push(P_V, 2, 4);
        push(P_D, 3, 4); push(P_W, 3, 9); push(P_V, 3, 5); push(P_R, 3, 2);
        lk_cpu = 1'b0;
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL vidup_loss cycle %0d: outputs %b, expected %b", k, w_obs, exp);
            end
            if (k == 3)  lk_cpu = 1'b1;
            if (k == 17) lk_cpu = 1'b0;
            if (k == 20) lk_cpu = 1'b1;
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp;
        sb.delete();
        push(P_R, 3, 2); push(P_D, 4, 4); push(P_W, 4, 9); push(P_V, 4, 2);
        lk_vid = 1'b0;
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL mid_reset_pre cycle %0d: outputs %b, expected %b", k, w_obs, exp);
            end
            if (k == 3) lk_vid = 1'b1;
        end
        // Assert RST between clock edges; outputs must react before the next edge.
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (w_obs !== {P_D, 4'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_async: outputs %b, expected %b", w_obs, {P_D, 4'd0});
        end
        test_bring_up("mid_reset_rerun");
    endtask

    task automatic test_timeout();
        logic [7:0] exp;
        rst = 1'b1; lk_cpu = 1'b1; lk_vid = 1'b0;
        @(negedge clk);
        sb.delete();
        push(P_D, 0, 3); push(P_W, 0, 32);
        for (int n = 1; n <= 17; n++) begin
            push(P_D, (n > 15) ? 15 : n, 4);
            push(P_W, (n > 15) ? 15 : n, 32);
        end
        rst = 1'b0;
        for (int k = 1; sb.size() > 0; k++) begin
            @(negedge clk);
            exp = sb.pop_front();
            n_checks++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: outputs %b, expected %b", k, w_obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bring_up("bring_up");
        test_chatter();
        test_run_loss();
        test_vidup_loss();
        test_mid_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
